// File: rtl/coord_stream_gen.sv
// coord_stream_gen: raster-order (x,y) coordinate stream with sof/eol/eof markers, per-frame pan and frame counter
module coord_stream_gen #(
  parameter int X_SIZE   = 640,
  parameter int Y_SIZE   = 480,
  parameter int W        = 16,
  parameter int CENTERED = 1,
  parameter int FCNT_W   = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic signed [W-1:0] pan_x,
  input  logic signed [W-1:0] pan_y,
  input  logic                ready,
  output logic                valid,
  output logic signed [W-1:0] x,
  output logic signed [W-1:0] y,
  output logic                sof,
  output logic                eol,
  output logic                eof,
  output logic [FCNT_W-1:0]   frame_cnt,
  output logic                busy
);
  localparam int CW = $clog2(X_SIZE);
  localparam int RW = $clog2(Y_SIZE);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [W-1:0] pan_x_l, pan_y_l, bx, by;
  logic last_col, last_row, fire;
  always_comb begin
    busy     = state == RUN;
    valid    = busy;
    fire     = valid && ready;
    last_col = col == CW'(X_SIZE - 1);
    last_row = row == RW'(Y_SIZE - 1);
    sof      = valid && col == '0 && row == '0;
    eol      = valid && last_col;
    eof      = eol && last_row;
    bx       = CENTERED != 0 ? W'(col) - W'(X_SIZE / 2) : W'(col);
    by       = CENTERED != 0 ? W'(Y_SIZE / 2) - W'(row) : W'(row);
    x        = bx + pan_x_l;
    y        = by + pan_y_l;
  end
  // pan is relatched only when a new frame starts, either from IDLE or back-to-back at eof
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      pan_x_l   <= '0;
      pan_y_l   <= '0;
      frame_cnt <= '0;
    end else if (state == IDLE) begin
      col <= '0;
      row <= '0;
      if (enable) begin
        pan_x_l <= pan_x;
        pan_y_l <= pan_y;
        state   <= RUN;
      end
    end else if (fire) begin
      col <= last_col ? '0 : col + 1'b1;
      if (last_col) row <= last_row ? '0 : row + 1'b1;
      if (eof) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (enable) begin
          pan_x_l <= pan_x;
          pan_y_l <= pan_y;
        end else begin
          state <= IDLE;
        end
      end
    end
  end
endmodule
